// File: rtl/fp_arith_pkg.sv
// ----------------------------------------------------------------------------
// fp_arith_pkg
// Shared types and helpers for the fixed-point adder arbiter:
//   state_e     : arbiter FSM states (IDLE -> CALC -> RESP -> IDLE)
//   full_sum_w  : width of the full-precision sum of two WI.WF operands
//   out_w       : width of the resized WIO.WFO result
//   rr_next     : round-robin search for the next valid requester
// ----------------------------------------------------------------------------
package fp_arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_e;

   // Upper bound on requesters; rr_next works on vectors padded to this size.
   localparam int unsigned MAX_NREQ = 8;
   localparam int unsigned MAX_IDW  = 3;

   typedef struct packed {
      logic                found;
      logic [MAX_IDW-1:0]  idx;
   } rr_pick_t;

   // Sign-extending both operands by one bit makes the sum exact.
   function automatic int unsigned full_sum_w(input int unsigned wi, input int unsigned wf);
      return wi + wf + 1;
   endfunction

   function automatic int unsigned out_w(input int unsigned wio, input int unsigned wfo);
      return wio + wfo;
   endfunction

   // First valid requester at last+1, last+2, ... modulo n.
   function automatic rr_pick_t rr_next(input logic [MAX_NREQ-1:0] valid,
                                        input logic [MAX_IDW-1:0]  last,
                                        input int unsigned         n);
      rr_pick_t           p;
      logic [MAX_IDW-1:0] pos;
      p.found = 1'b0;
      p.idx   = '0;
      for (int unsigned k = 1; k <= MAX_NREQ; k++) begin
         if (k <= n) begin
            pos = MAX_IDW'((32'(last) + k) % n);
            if (!p.found && valid[pos]) begin
               p.found = 1'b1;
               p.idx   = pos;
            end
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/fp_add_core.sv
// ----------------------------------------------------------------------------
// fp_add_core
// Combinational signed fixed-point adder: WI.WF + WI.WF -> WIO.WFO.
// The fraction is truncated or zero-padded, the integer part is sign-extended
// or has its MSBs dropped, with overflow detection on the dropped bits.
// Optional macro FP_ADD_ARB_SAT_EN: saturate the result on overflow.
// Ports:
//   op_a_i, op_b_i : operands, WI.WF two's complement
//   sum_o          : resized sum, WIO.WFO two's complement
//   ovf_o          : result does not fit in WIO.WFO
// ----------------------------------------------------------------------------
module fp_add_core
   import fp_arith_pkg::*;
#(
   parameter int unsigned WI  = 8,
   parameter int unsigned WF  = 10,
   parameter int unsigned WIO = 9,
   parameter int unsigned WFO = 10
) (
   input  logic [WI+WF-1:0]   op_a_i,
   input  logic [WI+WF-1:0]   op_b_i,
   output logic [WIO+WFO-1:0] sum_o,
   output logic               ovf_o
);

   localparam int unsigned FW = full_sum_w(WI, WF);
   localparam int unsigned OW = out_w(WIO, WFO);
   // Full sum after fraction alignment: (WI+1).WFO
   localparam int unsigned TW = WI + 1 + WFO;

   logic signed [FW-1:0] full_sum;
   logic signed [TW-1:0] aligned;
   logic [OW-1:0]        wrapped;
   logic                 ovf;

   assign full_sum = $signed({op_a_i[WI+WF-1], op_a_i}) + $signed({op_b_i[WI+WF-1], op_b_i});

   // Fraction alignment: arithmetic shift right truncates toward -inf.
   if (WFO < WF) begin : g_frac_trunc
      assign aligned = TW'(full_sum >>> (WF - WFO));
   end else begin : g_frac_pad
      assign aligned = TW'(full_sum) <<< (WFO - WF);
   end

   // Integer resize; in the drop case the kept MSB plus every dropped bit
   // must all equal the sign, otherwise the value changed.
   if (OW >= TW) begin : g_int_ext
      assign wrapped = OW'(aligned);
      assign ovf     = 1'b0;
   end else begin : g_int_drop
      logic signed [TW-1:0] upper;
      assign upper   = aligned >>> (OW - 1);
      assign wrapped = OW'(aligned);
      assign ovf     = (upper != '0) && (upper != '1);
   end

`ifdef FP_ADD_ARB_SAT_EN
   logic [OW-1:0] sat_val;
   assign sat_val = full_sum[FW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
   assign sum_o   = ovf ? sat_val : wrapped;
`else
   assign sum_o   = wrapped;
`endif

   assign ovf_o = ovf;

endmodule

// File: rtl/fp_add_arbiter.sv
// ----------------------------------------------------------------------------
// fp_add_arbiter
// Shares one fixed-point adder between NREQ requesters using round-robin
// arbitration. One operation per IDLE -> CALC -> RESP pass; the result is
// held on a single response channel tagged with the requester index.
// Optional macro FP_ADD_ARB_SAT_EN (in fp_add_core): saturate on overflow.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester handshake; req_ready one-hot or zero
//   req_a, req_b          : flattened WI.WF operands, requester i in slice i
//   rsp_valid/rsp_ready   : response handshake
//   rsp_data, rsp_ovf     : WIO.WFO sum and its overflow flag
//   rsp_id                : index of the requester owning the result
//   busy                  : FSM is not in IDLE
// ----------------------------------------------------------------------------
module fp_add_arbiter
   import fp_arith_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned WI   = 8,
   parameter int unsigned WF   = 10,
   parameter int unsigned WIO  = 9,
   parameter int unsigned WFO  = 10
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NREQ-1:0]              req_valid,
   output logic [NREQ-1:0]              req_ready,
   input  logic [NREQ*(WI+WF)-1:0]      req_a,
   input  logic [NREQ*(WI+WF)-1:0]      req_b,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [WIO+WFO-1:0]           rsp_data,
   output logic                         rsp_ovf,
   output logic [$clog2(NREQ)-1:0]      rsp_id,
   output logic                         busy
);

   localparam int unsigned IDW = $clog2(NREQ);
   localparam int unsigned OPW = WI + WF;
   localparam int unsigned OW  = out_w(WIO, WFO);

   state_e          state_q;
   logic [IDW-1:0]  last_q;
   logic [IDW-1:0]  gid_q;
   logic [OPW-1:0]  op_a_q;
   logic [OPW-1:0]  op_b_q;
   logic            rsp_valid_q;
   logic [OW-1:0]   rsp_data_q;
   logic            rsp_ovf_q;
   logic [IDW-1:0]  rsp_id_q;
   logic            busy_q;

   rr_pick_t        pick_c;
   logic [IDW-1:0]  gnt_idx_c;
   logic            gnt_c;
   logic [OPW-1:0]  sel_a_c;
   logic [OPW-1:0]  sel_b_c;

   logic [OW-1:0]   core_sum;
   logic            core_ovf;

   // Combinational grant, only offered while IDLE.
   always_comb begin
      pick_c    = rr_next(MAX_NREQ'(req_valid), MAX_IDW'(last_q), NREQ);
      gnt_idx_c = IDW'(pick_c.idx);
      gnt_c     = pick_c.found && (state_q == IDLE);
      req_ready = '0;
      if (gnt_c) begin
         req_ready = {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx_c;
      end
   end

   assign sel_a_c = req_a[32'(gnt_idx_c) * OPW +: OPW];
   assign sel_b_c = req_b[32'(gnt_idx_c) * OPW +: OPW];

   fp_add_core #(
      .WI  (WI),
      .WF  (WF),
      .WIO (WIO),
      .WFO (WFO)
   ) u_core (
      .op_a_i (op_a_q),
      .op_b_i (op_b_q),
      .sum_o  (core_sum),
      .ovf_o  (core_ovf)
   );

   // FSM, operand capture and registered response.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         last_q      <= IDW'(NREQ - 1);
         gid_q       <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_ovf_q   <= 1'b0;
         rsp_id_q    <= '0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gnt_c) begin
                  op_a_q  <= sel_a_c;
                  op_b_q  <= sel_b_c;
                  gid_q   <= gnt_idx_c;
                  last_q  <= gnt_idx_c;
                  state_q <= CALC;
                  busy_q  <= 1'b1;
               end
            end
            CALC: begin
               rsp_data_q  <= core_sum;
               rsp_ovf_q   <= core_ovf;
               rsp_id_q    <= gid_q;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               rsp_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_ovf   = rsp_ovf_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fp_add_arbiter
// Two instances share all inputs: the default build (WIO=9) and a WIO=8
// variant that can overflow. Directed table, backpressure and reset
// sequences, then round-robin and random traffic against a reference model.
// ----------------------------------------------------------------------------
module tb_fp_add_arbiter;

   localparam int unsigned NREQ = 4;
   localparam int unsigned WI   = 8;
   localparam int unsigned WF   = 10;
   localparam int unsigned WFO  = 10;
   localparam int unsigned OPW  = WI + WF;

`ifdef FP_ADD_ARB_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic                  clk;
   logic                  reset;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*OPW-1:0]   req_a;
   logic [NREQ*OPW-1:0]   req_b;
   logic                  rsp_ready;

   logic [NREQ-1:0]       req_ready;
   logic                  rsp_valid;
   logic [18:0]           rsp_data;
   logic                  rsp_ovf;
   logic [1:0]            rsp_id;
   logic                  busy;

   logic [NREQ-1:0]       w_req_ready;
   logic                  w_rsp_valid;
   logic [17:0]           w_rsp_data;
   logic                  w_rsp_ovf;
   logic [1:0]            w_rsp_id;
   logic                  w_busy;

   int npass = 0;
   int ntot  = 0;
   int mdl_last;
   int grants[NREQ];

   fp_add_arbiter #(.NREQ(NREQ), .WI(WI), .WF(WF), .WIO(9), .WFO(WFO)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_ovf   (rsp_ovf),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   fp_add_arbiter #(.NREQ(NREQ), .WI(WI), .WF(WF), .WIO(8), .WFO(WFO)) u_dut_w8 (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (w_req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (w_rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (w_rsp_data),
      .rsp_ovf   (w_rsp_ovf),
      .rsp_id    (w_rsp_id),
      .busy      (w_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
   endtask

   // Reference: exact integer sum, rescaled, range-checked against WIO.WFO.
   function automatic logic [19:0] ref_add(input logic [17:0] a, input logic [17:0] b, input int wio);
      longint s, hi, lo, res;
      int     ow;
      logic   ovf;
      s = longint'($signed(a)) + longint'($signed(b));
      if (WFO >= WF) s = s * (longint'(1) <<< (WFO - WF));
      else           s = s >>> (WF - WFO);
      ow  = wio + int'(WFO);
      hi  = (longint'(1) <<< (ow - 1)) - 1;
      lo  = -(longint'(1) <<< (ow - 1));
      ovf = (s > hi) || (s < lo);
      res = s & ((longint'(1) <<< ow) - 1);
      if (ovf && SAT) res = (s < 0) ? (longint'(1) <<< (ow - 1)) : hi;
      return {ovf, res[18:0]};
   endfunction

   function automatic int model_pick(input logic [3:0] mask, input int last);
      for (int k = 1; k <= int'(NREQ); k++) begin
         if (mask[(last + k) % NREQ]) return (last + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [17:0] rnd_op();
      case ($urandom_range(0, 5))
         0:       return 18'h1FFFF;
         1:       return 18'h20000;
         default: return 18'($urandom);
      endcase
   endfunction

   task automatic rand_data();
      for (int i = 0; i < int'(NREQ); i++) begin
         req_a[i*OPW +: OPW] = rnd_op();
         req_b[i*OPW +: OPW] = rnd_op();
      end
   endtask

   // Single-requester operation on requester r; checks both instances.
   task automatic run_op(input int r, input logic [17:0] a, input logic [17:0] b,
                         input logic [18:0] e9, input logic [17:0] e8, input logic eo8);
      int cnt;
      req_a[r*OPW +: OPW] = a;
      req_b[r*OPW +: OPW] = b;
      req_valid = 4'b0001 << r;
      #1;
      cnt = 0;
      while (!req_ready[r] && cnt < 20) begin @(negedge clk); #1; cnt++; end
      check("tbl_grant", 32'(req_ready), 32'(1) << r);
      @(posedge clk); #1;
      req_valid = '0;
      @(posedge clk); #1;
      check("tbl_latency", 32'(rsp_valid), 1);
      check("tbl_latency_w8", 32'(w_rsp_valid), 1);
      check("tbl_data", 32'(rsp_data), 32'(e9));
      check("tbl_ovf", 32'(rsp_ovf), 0);
      check("tbl_id", 32'(rsp_id), r);
      check("tbl_data_w8", 32'(w_rsp_data), 32'(e8));
      check("tbl_ovf_w8", 32'(w_rsp_ovf), 32'(eo8));
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("tbl_rsp_clear", 32'(rsp_valid), 0);
      check("tbl_busy_clear", 32'(busy), 0);
      @(negedge clk);
   endtask

   // Arbitrated operation with mask held valid; rsp_ready assumed high.
   task automatic rr_op(input logic [3:0] mask, input int exp_g, output int g);
      int          cnt;
      logic [17:0] ea, eb;
      logic [19:0] r9, r8;
      req_valid = mask;
      #1;
      cnt = 0;
      while (req_ready == '0 && cnt < 20) begin @(negedge clk); #1; cnt++; end
      check("rr_grant", 32'(req_ready), 32'(1) << exp_g);
      g = exp_g;
      for (int i = 0; i < int'(NREQ); i++) if (req_ready[i]) g = i;
      ea = req_a[g*OPW +: OPW];
      eb = req_b[g*OPW +: OPW];
      @(posedge clk); #1;
      req_a[g*OPW +: OPW] = rnd_op();
      req_b[g*OPW +: OPW] = rnd_op();
      cnt = 0;
      while (!rsp_valid && cnt < 6) begin @(negedge clk); cnt++; end
      r9 = ref_add(ea, eb, 9);
      r8 = ref_add(ea, eb, 8);
      check("rr_rsp_valid", 32'(rsp_valid), 1);
      check("rr_id", 32'(rsp_id), g);
      check("rr_data", 32'(rsp_data), 32'(r9[18:0]));
      check("rr_ovf", 32'(rsp_ovf), 32'(r9[19]));
      check("rr_data_w8", 32'(w_rsp_data), 32'(r8[17:0]));
      check("rr_ovf_w8", 32'(w_rsp_ovf), 32'(r8[19]));
   endtask

   typedef struct {
      logic [17:0] a;
      logic [17:0] b;
      logic [18:0] d9;
      logic [17:0] w8;
      logic [17:0] s8;
      logic        o8;
   } vec_t;

   vec_t vt[10];

   initial begin
      int g;
      logic [3:0] mask;

      vt[0] = '{18'h00600, 18'h00900, 19'h00F00, 18'h00F00, 18'h00F00, 1'b0};
      vt[1] = '{18'h3FC00, 18'h3FE00, 19'h7FA00, 18'h3FA00, 18'h3FA00, 1'b0};
      vt[2] = '{18'h19000, 18'h19000, 19'h32000, 18'h32000, 18'h1FFFF, 1'b1};
      vt[3] = '{18'h1FFFF, 18'h1FFFF, 19'h3FFFE, 18'h3FFFE, 18'h1FFFF, 1'b1};
      vt[4] = '{18'h20000, 18'h20000, 19'h40000, 18'h00000, 18'h20000, 1'b1};
      vt[5] = '{18'h00000, 18'h3FFFF, 19'h7FFFF, 18'h3FFFF, 18'h3FFFF, 1'b0};
      vt[6] = '{18'h00400, 18'h3FC00, 19'h00000, 18'h00000, 18'h00000, 1'b0};
      vt[7] = '{18'h20000, 18'h3FC00, 19'h5FC00, 18'h1FC00, 18'h20000, 1'b1};
      vt[8] = '{18'h1FC00, 18'h00400, 19'h20000, 18'h20000, 18'h1FFFF, 1'b1};
      vt[9] = '{18'h3F000, 18'h3F000, 19'h7E000, 18'h3E000, 18'h3E000, 1'b0};

      reset     = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_data", 32'(rsp_data), 0);
      check("rst_rsp_ovf", 32'(rsp_ovf), 0);
      check("rst_rsp_id", 32'(rsp_id), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_ready_idle", 32'(req_ready), 0);
      req_valid = 4'hF;
      #1;
      check("rst_first_priority", 32'(req_ready), 32'h1);
      req_valid = '0;
      @(negedge clk);

      // Directed vectors
      for (int i = 0; i < 10; i++) begin
         run_op(i % 4, vt[i].a, vt[i].b, vt[i].d9, SAT ? vt[i].s8 : vt[i].w8, vt[i].o8);
      end

      // Backpressure: response must hold while rsp_ready is low
      req_a[0 +: OPW] = 18'h00600;
      req_b[0 +: OPW] = 18'h00900;
      req_a[OPW +: OPW] = 18'h00400;
      req_b[OPW +: OPW] = 18'h00400;
      req_valid = 4'b0001;
      #1;
      for (int c = 0; c < 20 && !req_ready[0]; c++) begin @(negedge clk); #1; end
      @(posedge clk); #1;
      req_valid = 4'b0010;
      @(posedge clk); #1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp_valid", 32'(rsp_valid), 1);
         check("bp_data", 32'(rsp_data), 32'h00F00);
         check("bp_ovf", 32'(rsp_ovf), 0);
         check("bp_id", 32'(rsp_id), 0);
         check("bp_ready_low", 32'(req_ready), 0);
         check("bp_busy", 32'(busy), 1);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("bp_handshake", 32'(rsp_valid), 0);
      @(negedge clk); #1;
      check("bp_next_grant", 32'(req_ready), 32'h2);
      @(posedge clk); #1;
      req_valid = '0;
      @(posedge clk); #1;
      check("bp_req1_id", 32'(rsp_id), 1);
      check("bp_req1_data", 32'(rsp_data), 32'h00800);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      @(negedge clk);

      // Reset during CALC discards the operation and restores the pointer
      req_valid = 4'b0001;
      #1;
      for (int c = 0; c < 20 && !req_ready[0]; c++) begin @(negedge clk); #1; end
      @(posedge clk); #1;
      req_valid = '0;
      check("calc_busy", 32'(busy), 1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("calc_rst_valid", 32'(rsp_valid), 0);
      check("calc_rst_busy", 32'(busy), 0);
      check("calc_rst_valid_w8", 32'(w_rsp_valid), 0);
      @(negedge clk);
      reset = 1'b0;
      req_valid = 4'b0011;
      #1;
      check("calc_rst_pointer", 32'(req_ready), 32'h1);
      req_valid = '0;

      // Round-robin with every requester valid
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset     = 1'b0;
      rsp_ready = 1'b1;
      mdl_last  = int'(NREQ) - 1;
      rand_data();
      for (int k = 0; k < 12; k++) begin
         rr_op(4'hF, k % 4, g);
         grants[g]++;
         mdl_last = g;
      end
      for (int i = 0; i < int'(NREQ); i++) check("rr_fairness", grants[i], 3);

      // Random request masks and operands
      for (int k = 0; k < 30; k++) begin
         mask = 4'($urandom_range(1, 15));
         rand_data();
         rr_op(mask, model_pick(mask, mdl_last), g);
         mdl_last = g;
      end

      req_valid = '0;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      check("final_idle", 32'(busy), 0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/fp_add_arbiter.md
Name: fp_add_arbiter

Overview:
- Shares one fixed-point adder datapath between NREQ requesters, each of which presents operand pairs in WI.WF signed format.
- A round-robin arbiter grants one requester per operation. The block registers the operands, computes the sum and resizes it to WIO.WFO with overflow detection.
- The result is held on a single response channel, tagged with the requester ID.
- Sits between the DSP pipeline clients and the shared fixed-point arithmetic resource.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WI, 8, integer bits of each operand, sign bit included
- WF, 10, fractional bits of each operand
- WIO, 9, integer bits of the result
- WFO, 10, fractional bits of the result
- IDW, $clog2(NREQ), width of the requester ID (localparam)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester operand-pair valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_a  in  NREQ*(WI+WF)  flattened operand A; requester i occupies slice i
- req_b  in  NREQ*(WI+WF)  flattened operand B
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accept
- rsp_data  out  WIO+WFO  signed sum in WIO.WFO format
- rsp_ovf  out  1  overflow flag for rsp_data
- rsp_id  out  IDW  index of the requester that owns the result
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, rsp_valid=0, rsp_data=0, rsp_ovf=0, rsp_id=0, busy=0, last_grant=NREQ-1 (so requester 0 has first priority).
- FSM states: IDLE -> CALC -> RESP -> IDLE.
- IDLE:
  - req_ready is a combinational grant to the first valid requester, searching last_grant+1, +2, … modulo NREQ.
  - A transfer happens on req_valid[g] & req_ready[g]. On that edge: latch op_a, op_b and gid=g; set last_grant=g; go to CALC.
  - If no requester is valid, stay in IDLE.
- CALC:
  - req_ready=0.
  - The core output is registered into rsp_data, rsp_ovf and rsp_id=gid; set rsp_valid=1; go to RESP.
- RESP:
  - req_ready=0. rsp_valid=1.
  - rsp_data, rsp_ovf and rsp_id stay stable until rsp_ready.
  - On rsp_valid & rsp_ready: clear rsp_valid and go to IDLE.
- Latency and throughput: if a request is accepted at edge N, rsp_valid is high after edge N+1. Throughput is at most one operation per 3 cycles.
- Arithmetic:
  - Full sum is (WI+1).WF, with both operands sign-extended by one bit.
  - Fraction: if WFO<WF, truncate the LSBs (no rounding). If WFO>=WF, zero-pad.
  - Integer: if WIO>=WI+1, sign-extend. Otherwise drop the MSBs.
  - rsp_ovf=1 when the dropped MSBs are not all equal to the sign of the full sum.
- Simultaneous valids: exactly one grant per arbitration. Requesters that are not granted must hold req_valid and their data.
- A requester that deasserts req_valid before its grant is simply skipped; no state is kept for it.
- Reset asserted in any state: on the next edge the FSM is in IDLE, rsp_valid=0, the in-flight operation is discarded and the pointer is restored.

Optional Feature:
- Macro: FP_ADD_ARB_SAT_EN.
- Defined: when the core overflows, rsp_data saturates.
  - Sign of the full sum 0 → max positive, {0, all 1s}.
  - Sign of the full sum 1 → min negative, {1, all 0s}.
  - rsp_ovf is still asserted.
- Undefined: rsp_data is the wrapped, truncated value and rsp_ovf flags the overflow.

Decomposition:
- Package fp_arith_pkg:
  - state enum {IDLE, CALC, RESP}
  - width helper localparams / functions (full sum width WI+WF+1, output width WIO+WFO)
  - round-robin next-index function
- Sub-module fp_add_core:
  - combinational: op_a, op_b → sum and ovf in WIO.WFO
  - contains the resize, overflow and (macro-gated) saturation logic
  - instanced once inside fp_add_arbiter

Test Plan (defaults unless noted):
- Basic: req0 sends A=0x00600 (1.5) and B=0x00900 (2.25) → two cycles after accept: rsp_valid=1, rsp_data=0x00F00 (3.75), rsp_ovf=0, rsp_id=0.
- Round-robin: all four req_valid held high for 12 operations → grant order 0,1,2,3,0,1,2,3,…; rsp_id follows the same order; no requester starved.
- Backpressure: rsp_ready held low for 5 cycles in RESP → rsp_data, rsp_ovf and rsp_id stable; req_ready=0 throughout; one handshake when rsp_ready rises.
- Overflow with WIO=8 override: A=B=0x19000 (100.0) →
  - without the macro: rsp_ovf=1, rsp_data=0x32000 (-56.0, wrapped);
  - with FP_ADD_ARB_SAT_EN: rsp_data=0x1FFFF, rsp_ovf=1.
- Negative operands: A=0x3FC00 (-1.0) and B=0x3FE00 (-0.5) → rsp_data=0x7FA00 (-1.5), rsp_ovf=0.
- Reset during CALC → next cycle: rsp_valid=0, busy=0. With req1 and req0 both valid afterwards, req0 is granted first.
